// File: rtl/jregbank_if.sv
// Control and observation signals of the bus-side register bank.
// The shared tri-state data bus is not part of this bundle; it stays a plain
// net so it can be resolved together with every other driver on the CPU bus.
interface jregbank_if #(
    parameter int NREG = 4,
    parameter int AW   = 2
);
    logic               ws;
    logic [AW-1:0]      bsel_s;
    logic               we;
    logic [AW-1:0]      bsel_e;
    logic [NREG-1:0]    bvalid;
    logic [8*NREG-1:0]  bpeek;
    logic               wlast_we;

    // Sequencer side: issues strobes and selects, observes status.
    modport master (
        output ws, bsel_s, we, bsel_e,
        input  bvalid, bpeek, wlast_we
    );

    // Register bank side.
    modport slave (
        input  ws, bsel_s, we, bsel_e,
        output bvalid, bpeek, wlast_we
    );
endinterface

// File: rtl/jregbank.sv
// Bus-side register bank: NREG byte registers that capture the shared bus on
// the set strobe and drive a selected register back onto it on enable.
// A transfer between two registers needs no extra logic: the enable path puts
// reg[bsel_e] on the bus and the set path captures that same bus value.
module jregbank #(
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic       wclk,
    input  logic       wreset,
    inout  wire  [7:0] bbus,
    jregbank_if.slave  bif
);
    logic [NREG-1:0][7:0] reg_q;
    logic [NREG-1:0][7:0] reg_d;
    logic [NREG-1:0]      valid_q;
    logic [NREG-1:0]      valid_d;
    logic                 last_we_q;
    logic [7:0]           rd_data;
    logic                 drive_en;

    // Next-state for the storage: only the register selected for set changes.
    always_comb begin
        reg_d   = reg_q;
        valid_d = valid_q;
        if (bif.ws) begin
            reg_d[bif.bsel_s]   = bbus;
            valid_d[bif.bsel_s] = 1'b1;
        end
    end

    // Registers, valid flags and the turnaround flag; reset clears everything.
    always_ff @(posedge wclk or posedge wreset) begin
        if (wreset) begin
            reg_q     <= '0;
            valid_q   <= '0;
            last_we_q <= 1'b0;
        end else begin
            reg_q     <= reg_d;
            valid_q   <= valid_d;
            last_we_q <= bif.we;
        end
    end

    // Enable path is purely combinational; reset releases the bus at once.
    assign rd_data  = reg_q[bif.bsel_e];
    assign drive_en = bif.we && !wreset;
    assign bbus     = drive_en ? rd_data : 8'hzz;

    assign bif.bvalid   = valid_q;
    assign bif.bpeek    = reg_q;
    assign bif.wlast_we = last_we_q;
endmodule

// File: tb/tb_jregbank.sv
`timescale 1ns/1ps
module tb_jregbank;
    logic       wclk;
    logic       wreset;
    wire  [7:0] bbus;
    logic       drv_en;
    logic [7:0] drv_val;
    int         n_chk;
    int         n_pass;

    jregbank_if #(.NREG(4), .AW(2)) bif ();

    jregbank #(.NREG(4), .AW(2)) dut (
        .wclk   (wclk),
        .wreset (wreset),
        .bbus   (bbus),
        .bif    (bif)
    );

    // External bus driver plus a weak pull-up: a released bus reads 0xFF.
    assign bbus = drv_en ? drv_val : 8'hzz;
    pullup (bbus);

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        drv_en     = 1'b0;
        drv_val    = 8'h00;
        wreset     = 1'b1;
        bif.ws     = 1'b0;
        bif.bsel_s = 2'd0;
        bif.we     = 1'b1;
        bif.bsel_e = 2'd0;
        #1;
        chk("reset_bus_released", {24'h0, bbus}, 32'h0000_00ff);
        chk("reset_bpeek",        bif.bpeek, 32'h0);
        chk("reset_bvalid",       {28'h0, bif.bvalid}, 32'h0);
        chk("reset_wlast_we",     {31'h0, bif.wlast_we}, 32'h0);
        tick();
        chk("reset_wlast_held",   {31'h0, bif.wlast_we}, 32'h0);
        #2;
        wreset = 1'b0;
        bif.we = 1'b0;

        // Set R2 from the bus, then read it back through the enable path.
        tick();
        drv_en = 1'b1; drv_val = 8'hA5; bif.ws = 1'b1; bif.bsel_s = 2'd2;
        tick();
        drv_en = 1'b0; bif.ws = 1'b0; bif.we = 1'b1; bif.bsel_e = 2'd2;
        #1;
        chk("set_readback_bus", {24'h0, bbus}, 32'h0000_00a5);
        chk("set_bvalid",       {28'h0, bif.bvalid}, 32'h4);
        chk("set_bpeek",        bif.bpeek, 32'h00a5_0000);
        chk("set_wlast_we",     {31'h0, bif.wlast_we}, 32'h0);

        // Enable a register never set: drives 0x00, its valid stays clear.
        bif.bsel_e = 2'd1;
        #1;
        chk("enable_unset_bus", {24'h0, bbus}, 32'h0);
        tick();
        chk("enable_unset_bvalid", {28'h0, bif.bvalid}, 32'h4);
        chk("enable_wlast_we",     {31'h0, bif.wlast_we}, 32'h1);

        // Preload R1 = 0x3C, then transfer R1 -> R3 with no external driver.
        bif.we = 1'b0;
        drv_en = 1'b1; drv_val = 8'h3C; bif.ws = 1'b1; bif.bsel_s = 2'd1;
        tick();
        drv_en = 1'b0; bif.bsel_s = 2'd3; bif.we = 1'b1; bif.bsel_e = 2'd1;
        #1;
        chk("transfer_bus", {24'h0, bbus}, 32'h0000_003c);
        tick();
        bif.ws = 1'b0;
        chk("transfer_bpeek",  bif.bpeek, 32'h3ca5_3c00);
        chk("transfer_bvalid", {28'h0, bif.bvalid}, 32'he);

        // Self-copy of R0 for three edges keeps the value stable.
        bif.we = 1'b0;
        #1;
        drv_en = 1'b1; drv_val = 8'h7E; bif.ws = 1'b1; bif.bsel_s = 2'd0;
        tick();
        drv_en = 1'b0; bif.we = 1'b1; bif.bsel_e = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("selfcopy_bus", {24'h0, bbus}, 32'h0000_007e);
            chk("selfcopy_r0",  {24'h0, bif.bpeek[7:0]}, 32'h0000_007e);
        end
        bif.ws = 1'b0;
        chk("selfcopy_bvalid", {28'h0, bif.bvalid}, 32'hf);

        // Turnaround flag follows we delayed by one edge.
        bif.we = 1'b1;
        tick();
        chk("wlast_we_1", {31'h0, bif.wlast_we}, 32'h1);
        bif.we = 1'b0;
        tick();
        chk("wlast_we_0", {31'h0, bif.wlast_we}, 32'h0);
        bif.we = 1'b1;
        tick();
        chk("wlast_we_1b", {31'h0, bif.wlast_we}, 32'h1);

        // Load R2 = 0xFF, then reset in the middle of a pending transfer.
        bif.we = 1'b0;
        #1;
        drv_en = 1'b1; drv_val = 8'hFF; bif.ws = 1'b1; bif.bsel_s = 2'd2;
        tick();
        drv_en = 1'b0; bif.ws = 1'b0; bif.we = 1'b1; bif.bsel_e = 2'd2;
        tick();
        chk("pre_reset_r2", {24'h0, bif.bpeek[23:16]}, 32'h0000_00ff);
        bif.ws = 1'b1; bif.bsel_s = 2'd3;
        #2;
        wreset = 1'b1;
        #1;
        chk("midreset_bus_released", {24'h0, bbus}, 32'h0000_00ff);
        chk("midreset_bpeek",        bif.bpeek, 32'h0);
        chk("midreset_bvalid",       {28'h0, bif.bvalid}, 32'h0);
        chk("midreset_wlast_we",     {31'h0, bif.wlast_we}, 32'h0);
        tick();
        chk("midreset_pending_lost", {28'h0, bif.bvalid}, 32'h0);
        bif.ws = 1'b0; bif.we = 1'b0;
        #2;
        wreset = 1'b0;

        // First set after reset release works normally.
        tick();
        drv_en = 1'b1; drv_val = 8'h5A; bif.ws = 1'b1; bif.bsel_s = 2'd3;
        tick();
        drv_en = 1'b0; bif.ws = 1'b0;
        chk("post_reset_bpeek",  bif.bpeek, 32'h5a00_0000);
        chk("post_reset_bvalid", {28'h0, bif.bvalid}, 32'h8);
        bif.we = 1'b1; bif.bsel_e = 2'd3;
        #1;
        chk("post_reset_bus", {24'h0, bbus}, 32'h0000_005a);
        bif.we = 1'b0;
        #1;
        chk("final_bus_released", {24'h0, bbus}, 32'h0000_00ff);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/jregbank.md
# jregbank

Bus-side register bank: the receiving end of the byte enabler on the shared 8-bit CPU bus. It holds NREG byte registers. Each clock it captures the bus into the register selected for "set", and drives the register selected for "enable" back onto the bus through a tri-state path. It serves as the general-purpose register file (R0–R3) between the bus, the ALU operand latches and the control sequencer.

## Interface
Parameters:
- NREG, default 4: number of byte registers; power of two, 2..8.
- AW, default 2: select width; must equal log2(NREG).

Ports:
- wclk, input, 1: system clock; all state changes on the rising edge.
- wreset, input, 1: asynchronous, active-high reset.
- bbus, inout, 8: shared CPU bus. Sampled on set; driven on enable.
- ws, input, 1: set strobe; capture the bus into register bsel_s on the next rising edge.
- bsel_s, input, AW: index of the register to set.
- we, input, 1: enable strobe; drive register bsel_e onto bbus.
- bsel_e, input, AW: index of the register to enable.
- bvalid, output, NREG: bit k is 1 once register k has been set since reset.
- bpeek, output, 8·NREG: all register contents concatenated, register k in bits [8k+7:8k]. Used for debug and ALU taps.
- wlast_we, output, 1: registered copy of "enable was active last cycle"; used by the sequencer for bus-turnaround checks.

## Operation
- **Storage.** NREG × 8-bit registers reg[k] and NREG valid flags.
- **Set.** On a rising wclk with ws=1:
  - reg[bsel_s] ← bbus.
  - bvalid[bsel_s] ← 1.
  - All other registers hold.
- **Enable.** While we=1 and wreset=0, bbus = reg[bsel_e] (combinational, no clock). When we=0 or wreset=1, all 8 bbus bits are high-Z.
- **Transfer, same cycle.** ws=1, we=1, bsel_s≠bsel_e: reg[bsel_s] ← reg[bsel_e] at the edge. The bank is the only bus driver in this case; the external controller keeps all other drivers off.
- **Self-copy.** ws=1, we=1, bsel_s=bsel_e: the register keeps its value. bvalid for that index still becomes 1.
- **Unknown bits.** A set with undriven bus bits (no driver active) captures X/Z as-is. The bank does not mask them; the controller is responsible for never doing this.
- **Valid flags** are sticky until reset. They never clear on enable.
- **wlast_we** ← we on every rising edge.

## Timing
- **Reset values** (asynchronous, on wreset=1, no clock needed):
  - all reg[k]=0x00
  - bvalid=0
  - wlast_we=0
  - bbus high-Z
  - bpeek=0
- **Release of reset.** The first rising edge after wreset falls is the first edge that can set a register.
- **Set latency.** The bus value present at edge n is visible on bpeek and on the enable path right after edge n (1-cycle write latency).
- **Enable latency.** Combinational from we/bsel_e to bbus; no registered stage.
- **Read-during-write.** Enabling register k in the same cycle register k is set with a different bus value is not allowed. Enable always shows the pre-edge value, so a legal self-copy is stable.
- **Select changes.** Changes to bsel_e while we=1 switch the drive combinationally. bsel_s matters only at the edge.
- **Reset mid-transfer.** wreset asserted while ws/we=1 releases the bus immediately and clears all state; the pending set is lost.
- **bvalid update.** Updates on the same edge as the data.

## Test plan
- **Reset:** assert wreset with we=1, bsel_e=0 → bbus=Z, bpeek=0, bvalid=0000, wlast_we=0.
- **Set/readback:**
  - Drive bbus=0xA5 with ws=1, bsel_s=2 for one edge; release.
  - Then we=1, bsel_e=2 → bbus=0xA5, bvalid=0100, bpeek[23:16]=0xA5.
- **Transfer:**
  - Preload R1=0x3C.
  - ws=1, bsel_s=3, we=1, bsel_e=1, external drivers off, one edge → R3=0x3C, R1=0x3C, bvalid[3]=1.
- **Self-copy:** R0=0x7E; ws=1, we=1, both selects=0 for 3 edges → R0 stays 0x7E, bus stable 0x7E.
- **Async reset mid-operation:**
  - R2=0xFF; assert wreset between edges while we=1, bsel_e=2 → bbus goes Z within the same timestep, R2=0x00, bvalid=0.
  - Next set after release works.
- **Turnaround flag:** we pattern 1,0,1 over 3 edges → wlast_we 1,0,1 delayed one cycle. Enable with no prior set → bbus=0x00, bvalid bit stays 0.
